// File: rtl/tjrpu_wb_regs.sv
// tjrpu_wb_regs: Wishbone classic slave holding the tjrpu control/status registers.
// Terminates the Caravel management bus and provides the following:
// - 16 user pads: io_out, io_oeb and a synchronised io_in.
// - Three maskable user interrupts.
// - A host-to-core mailbox FIFO with first-word fall-through.
// Ports:
//   wb_clk_i, wb_rst_i      clock, asynchronous active-high reset
//   wbs_*                   Wishbone classic slave (1-cycle registered ack)
//   io_in/io_out/io_oeb     pad input, pad output, active-low output enable
//   irq                     user interrupts (IRQ_STAT & IRQ_EN, registered)
//   core_run, core_srst     core run enable, one-cycle soft reset pulse
//   core_event              single-cycle event pulse from the core
//   mbox_data/valid/ready   mailbox head word and pop handshake
module tjrpu_wb_regs #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK  = 32'hFFFF_FF00,
  parameter int unsigned NIO        = 16,
  parameter int unsigned MBOX_DEPTH = 4
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  input  logic [NIO-1:0]  io_in,
  output logic [NIO-1:0]  io_out,
  output logic [NIO-1:0]  io_oeb,
  output logic [2:0]      irq,
  output logic            core_run,
  output logic            core_srst,
  input  logic            core_event,
  output logic [31:0]     mbox_data,
  output logic            mbox_valid,
  input  logic            mbox_ready
);

  localparam int unsigned PW = $clog2(MBOX_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] CntFull = CW'(MBOX_DEPTH);
  localparam logic [CW-1:0] CntOne  = CW'(1);

  localparam logic [5:0] OffCtrl   = 6'h00;
  localparam logic [5:0] OffGpOut  = 6'h01;
  localparam logic [5:0] OffGpOe   = 6'h02;
  localparam logic [5:0] OffGpIn   = 6'h03;
  localparam logic [5:0] OffIrqSt  = 6'h04;
  localparam logic [5:0] OffIrqEn  = 6'h05;
  localparam logic [5:0] OffPush   = 6'h06;
  localparam logic [5:0] OffMstat  = 6'h07;

  logic            r_ack;
  logic [31:0]     r_dat;
  logic            r_run, r_srst;
  logic [NIO-1:0]  r_gpio_out, r_gpio_oe;
  logic [NIO-1:0]  r_sync1, r_sync2;
  logic            r_in0_prev;
  logic [2:0]      r_irq_stat, r_irq_en, r_irq;
  logic [31:0]     r_mem [MBOX_DEPTH];
  logic [PW-1:0]   r_wptr, r_rptr;
  logic [CW-1:0]   r_cnt;
  logic            r_ovf;

  logic            w_win, w_acc, w_wr, w_rd;
  logic [5:0]      w_off;
  logic [NIO-1:0]  w_bmask;
  logic [31:0]     w_rdata;
  logic            w_edge, w_full, w_pop, w_push_req, w_push, w_ovf_set, w_ovf_clr;
  logic            w_pop_empty;
  logic [2:0]      w_irq_set, w_irq_clr;
  logic [CW-1:0]   w_cnt_d;
  logic            w_unused;

  assign w_win = (wbs_adr_i & ADDR_MASK) == BASE_ADDR;
  // Blocking on r_ack forces a dead cycle between back-to-back transfers.
  assign w_acc = wbs_cyc_i & wbs_stb_i & ~r_ack & w_win;
  assign w_wr  = w_acc & wbs_we_i;
  assign w_rd  = w_acc & ~wbs_we_i;
  assign w_off = wbs_adr_i[7:2];

  // Per-bit write enable from the byte selects (NIO <= 32).
  for (genvar b = 0; b < NIO; b++) begin : g_bmask
    assign w_bmask[b] = wbs_sel_i[b / 8];
  end

  // Some select lanes have no register behind them when NIO is small.
  assign w_unused = ^wbs_sel_i;

  // Rising edge of the synchronised pad 0; prev resets to 0 with the sync flops,
  // so the first post-reset cycle always compares 0 against 0.
  assign w_edge = r_sync2[0] & ~r_in0_prev;

  // Mailbox FIFO control.
  assign w_full      = r_cnt == CntFull;
  assign w_pop       = (r_cnt != '0) & mbox_ready;
  assign w_push_req  = w_wr & (w_off == OffPush);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push      = w_push_req & (~w_full | w_pop);
  assign w_ovf_set   = w_push_req & w_full & ~w_pop;
  assign w_ovf_clr   = w_wr & (w_off == OffMstat) & wbs_sel_i[1] & wbs_dat_i[8];
  assign w_pop_empty = w_pop & ~w_push & (r_cnt == CntOne);

  always_comb begin
    w_cnt_d = r_cnt;
    if (w_push && !w_pop) w_cnt_d = r_cnt + CntOne;
    else if (!w_push && w_pop) w_cnt_d = r_cnt - CntOne;
  end

  assign w_irq_set = {w_pop_empty, core_event, w_edge};
  assign w_irq_clr = (w_wr && w_off == OffIrqSt) ? (wbs_dat_i[2:0] & w_bmask[2:0]) : 3'b000;

  always_comb begin
    w_rdata = '0;
    unique case (w_off)
      OffCtrl:  w_rdata[0] = r_run;
      OffGpOut: w_rdata[NIO-1:0] = r_gpio_out;
      OffGpOe:  w_rdata[NIO-1:0] = r_gpio_oe;
      OffGpIn:  w_rdata[NIO-1:0] = r_sync2;
      OffIrqSt: w_rdata[2:0] = r_irq_stat;
      OffIrqEn: w_rdata[2:0] = r_irq_en;
      OffMstat: begin
        w_rdata[CW-1:0] = r_cnt;
        w_rdata[8]      = r_ovf;
      end
      default:  w_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_ack      <= 1'b0;
      r_dat      <= '0;
      r_run      <= 1'b0;
      r_srst     <= 1'b0;
      r_gpio_out <= '0;
      r_gpio_oe  <= '0;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_in0_prev <= 1'b0;
      r_irq_stat <= '0;
      r_irq_en   <= '0;
      r_irq      <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      for (int unsigned i = 0; i < MBOX_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_ack <= w_acc;
      r_dat <= w_rd ? w_rdata : '0;

      if (w_wr && w_off == OffCtrl && wbs_sel_i[0]) r_run <= wbs_dat_i[0];
      r_srst <= w_wr & (w_off == OffCtrl) & wbs_sel_i[0] & wbs_dat_i[1];

      if (w_wr && w_off == OffGpOut)
        r_gpio_out <= (r_gpio_out & ~w_bmask) | (wbs_dat_i[NIO-1:0] & w_bmask);
      if (w_wr && w_off == OffGpOe)
        r_gpio_oe <= (r_gpio_oe & ~w_bmask) | (wbs_dat_i[NIO-1:0] & w_bmask);
      if (w_wr && w_off == OffIrqEn)
        r_irq_en <= (r_irq_en & ~w_bmask[2:0]) | (wbs_dat_i[2:0] & w_bmask[2:0]);

      r_sync1    <= io_in;
      r_sync2    <= r_sync1;
      r_in0_prev <= r_sync2[0];

      // Set has priority over a coincident write-1-to-clear.
      r_irq_stat <= (r_irq_stat & ~w_irq_clr) | w_irq_set;
      r_irq      <= r_irq_stat & r_irq_en;

      if (w_push) begin
        r_mem[r_wptr] <= wbs_dat_i;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_cnt <= w_cnt_d;
      r_ovf <= (r_ovf & ~w_ovf_clr) | w_ovf_set;
    end
  end

  assign wbs_ack_o  = r_ack;
  assign wbs_dat_o  = r_dat;
  assign io_out     = r_gpio_out;
  assign io_oeb     = ~r_gpio_oe;
  assign irq        = r_irq;
  assign core_run   = r_run;
  assign core_srst  = r_srst;
  assign mbox_data  = r_mem[r_rptr];
  assign mbox_valid = r_cnt != '0;

endmodule
